spi_frame_decoder: RTL and testbench

SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

---
 rtl/spi_regs_pkg.sv | 34 +++
 rtl/spi_frame_decoder_if.sv | 32 +++
 rtl/spi_reg_bank.sv | 93 +++++++++
 rtl/spi_frame_decoder.sv | 122 ++++++++++++
 tb/tb_spi_frame_decoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_regs_pkg                                                    |
// | Brief  : Register map, reset defaults and FSM encoding for the SPI       |
// |          frame decoder.                                                  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package spi_regs_pkg;

   localparam int unsigned c_addr_w = 7;

   localparam logic [6:0] c_addr_id        = 7'h00;
   localparam logic [6:0] c_addr_ctrl      = 7'h01;
   localparam logic [6:0] c_addr_gain      = 7'h02;
   localparam logic [6:0] c_addr_status    = 7'h03;
   localparam logic [6:0] c_addr_sample_hi = 7'h04;
   localparam logic [6:0] c_addr_sample_lo = 7'h05;

   localparam logic [7:0] c_id_default   = 8'hEC;
   localparam logic [7:0] c_ctrl_default = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WRITE = 2'd2,
      READ  = 2'd3
   } state_t;

   function automatic logic is_mapped(input logic [6:0] addr);
      return (addr <= c_addr_sample_lo);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_frame_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_frame_decoder_if                                            |
// | Brief  : Byte-level handshake between an SPI slave PHY and the decoder.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface spi_frame_decoder_if;

   logic       cs_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_load;

   modport master (
      output cs_n,
      output rx_data,
      output rx_valid,
      input  tx_data,
      input  tx_load
   );

   modport slave (
      input  cs_n,
      input  rx_data,
      input  rx_valid,
      output tx_data,
      output tx_load
   );

endinterface
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_reg_bank                                                    |
// | Brief  : Register storage, read mux, sample shadow and sticky err flag.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_reg_bank
   import spi_regs_pkg::*;
#(
   parameter logic [7:0] ID_VALUE   = c_id_default,
   parameter logic [7:0] CTRL_RESET = c_ctrl_default
) (
   input  wire         clk,
   input  wire         reset,
   input  wire         frame_idle,
   input  wire         wr_en,
   input  wire  [6:0]  wr_addr,
   input  wire  [7:0]  wr_data,
   input  wire         rd_en,
   input  wire  [6:0]  rd_addr,
   input  wire  [15:0] sample,
   output logic [7:0]  rd_data,
   output logic        led,
   output logic        acq_en,
   output logic [7:0]  gain,
   output logic        err
);

   logic [7:0] r_ctrl;
   logic [7:0] r_gain;
   logic [7:0] r_shadow;
   logic       r_shadow_valid;
   logic       r_err;
   logic       w_unmapped_access;
   logic       w_err_clear;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl <= CTRL_RESET;
         r_gain <= '0;
      end else if (wr_en) begin
         if (wr_addr == c_addr_ctrl) r_ctrl <= wr_data;
         if (wr_addr == c_addr_gain) r_gain <= wr_data;
      end
   end

   // Shadow keeps a HI/LO read pair coherent; validity never outlives the frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow       <= '0;
         r_shadow_valid <= 1'b0;
      end else if (frame_idle) begin
         r_shadow_valid <= 1'b0;
      end else if (rd_en && (rd_addr == c_addr_sample_hi)) begin
         r_shadow       <= sample[7:0];
         r_shadow_valid <= 1'b1;
      end
   end

   assign w_unmapped_access = (wr_en && !is_mapped(wr_addr)) ||
                              (rd_en && !is_mapped(rd_addr));
   assign w_err_clear       = wr_en && (wr_addr == c_addr_status) && wr_data[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_unmapped_access) begin
         r_err <= 1'b1;
      end else if (w_err_clear) begin
         r_err <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         c_addr_id:        rd_data = ID_VALUE;
         c_addr_ctrl:      rd_data = r_ctrl;
         c_addr_gain:      rd_data = r_gain;
         c_addr_status:    rd_data = {7'b0, r_err};
         c_addr_sample_hi: rd_data = sample[15:8];
         c_addr_sample_lo: rd_data = r_shadow_valid ? r_shadow : sample[7:0];
         default:          rd_data = '0;
      endcase
   end

   assign led    = r_ctrl[0];
   assign acq_en = r_ctrl[1];
   assign gain   = r_gain;
   assign err    = r_err;

endmodule
`default_nettype wire

// File: rtl/spi_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spi_frame_decoder                                               |
// | Brief  : Decodes SPI command/data frames into register reads and writes. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_frame_decoder
   import spi_regs_pkg::*;
#(
   parameter logic [7:0] ID_VALUE   = c_id_default,
   parameter logic [7:0] CTRL_RESET = c_ctrl_default
) (
   input  wire                   clk,
   input  wire                   reset,
   spi_frame_decoder_if.slave    bus,
   input  wire  [15:0]           sample,
   output logic                  led,
   output logic                  acq_en,
   output logic [7:0]            gain,
   output logic                  err
);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_armed;
   logic [6:0] r_addr;
   logic [7:0] r_tx_data;
   logic       r_tx_load;

   logic       w_byte;
   logic       w_cmd_stb;
   logic       w_wr_stb;
   logic       w_rd_next_stb;
   logic       w_rd_en;
   logic [6:0] w_rd_addr;
   logic [6:0] w_addr_inc;
   logic [7:0] w_rd_data;

   // A byte only counts while the frame is still open.
   assign w_byte        = bus.rx_valid && !bus.cs_n;
   assign w_cmd_stb     = w_byte && (r_state == CMD);
   assign w_wr_stb      = w_byte && (r_state == WRITE);
   assign w_rd_next_stb = w_byte && (r_state == READ);
   assign w_addr_inc    = r_addr + 7'd1;
   assign w_rd_en       = (w_cmd_stb && !bus.rx_data[7]) || w_rd_next_stb;
   assign w_rd_addr     = w_cmd_stb ? bus.rx_data[6:0] : w_addr_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.cs_n) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (r_armed) w_state_next = CMD;
            CMD:     if (bus.rx_valid) w_state_next = bus.rx_data[7] ? WRITE : READ;
            default: w_state_next = r_state;
         endcase
      end
   end

   // After reset the decoder must see cs_n high before it trusts a frame start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_armed <= 1'b0;
      end else if (bus.cs_n) begin
         r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr <= '0;
      end else if (w_cmd_stb) begin
         r_addr <= bus.rx_data[6:0];
      end else if (w_wr_stb || w_rd_next_stb) begin
         r_addr <= w_addr_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_data <= '0;
         r_tx_load <= 1'b0;
      end else begin
         r_tx_load <= w_rd_en;
         if (w_rd_en) r_tx_data <= w_rd_data;
      end
   end

   assign bus.tx_data = r_tx_data;
   assign bus.tx_load = r_tx_load;

   spi_reg_bank #(
      .ID_VALUE   (ID_VALUE),
      .CTRL_RESET (CTRL_RESET)
   ) u_reg_bank (
      .clk        (clk),
      .reset      (reset),
      .frame_idle (bus.cs_n),
      .wr_en      (w_wr_stb),
      .wr_addr    (r_addr),
      .wr_data    (bus.rx_data),
      .rd_en      (w_rd_en),
      .rd_addr    (w_rd_addr),
      .sample     (sample),
      .rd_data    (w_rd_data),
      .led        (led),
      .acq_en     (acq_en),
      .gain       (gain),
      .err        (err)
   );

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_spi_frame_decoder                                            |
// | Brief  : Directed frame table plus hand-written reset/abort sequences.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_frame_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sample;
   logic        led;
   logic        acq_en;
   logic [7:0]  gain;
   logic        err;

   spi_frame_decoder_if bus();

   spi_frame_decoder #(
      .ID_VALUE   (8'hEC),
      .CTRL_RESET (8'h00)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .sample (sample),
      .led    (led),
      .acq_en (acq_en),
      .gain   (gain),
      .err    (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_loads = 0;

   always @(negedge clk) if (bus.tx_load === 1'b1) n_loads++;

   typedef struct packed {
      logic [1:0]       n;
      logic [2:0][7:0]  b;
      logic [2:0][15:0] smp;
      logic [2:0]       txv;
      logic [2:0][7:0]  tx;
      logic             led;
      logic             acq;
      logic [7:0]       gain;
      logic             err;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2,
                               input logic [15:0] s0, s1, input logic [2:0] txv,
                               input logic [7:0] t0, t1, t2, input logic l, a,
                               input logic [7:0] g, input logic e);
      vec_t v;
      v.n = n[1:0];
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
      v.smp[0] = s0; v.smp[1] = s1; v.smp[2] = s1;
      v.txv = txv;
      v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2;
      v.led = l; v.acq = a; v.gain = g; v.err = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulses one byte; samples the tx handshake in the following cycle.
   task automatic send_byte(input logic [7:0] d, input logic [15:0] s,
                            output logic ld, output logic [7:0] td);
      sample       = s;
      bus.rx_data  = d;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      @(negedge clk);
      ld = bus.tx_load;
      td = bus.tx_data;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic       ld;
      logic [7:0] td;
      int         l0;
      l0 = n_loads;
      bus.cs_n = 1'b0;
      tick(2);
      for (int j = 0; j < int'(v.n); j++) begin
         send_byte(v.b[j], v.smp[j], ld, td);
         chk($sformatf("v%0d.b%0d tx_load", idx, j), {15'b0, ld}, {15'b0, v.txv[j]});
         if (v.txv[j]) chk($sformatf("v%0d.b%0d tx_data", idx, j), {8'b0, td}, {8'b0, v.tx[j]});
         tick(1);
      end
      bus.cs_n = 1'b1;
      tick(2);
      chk($sformatf("v%0d load_count", idx), 16'(n_loads - l0), 16'($countones(v.txv)));
      chk($sformatf("v%0d led", idx),    {15'b0, led},    {15'b0, v.led});
      chk($sformatf("v%0d acq_en", idx), {15'b0, acq_en}, {15'b0, v.acq});
      chk($sformatf("v%0d gain", idx),   {8'b0, gain},    {8'b0, v.gain});
      chk($sformatf("v%0d err", idx),    {15'b0, err},    {15'b0, v.err});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ld;
      logic [7:0] td;
      int         l0;

      reset        = 1'b0;
      bus.cs_n     = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      sample       = 16'h1234;
      tick(3);
      chk("rst tx_load", {15'b0, bus.tx_load}, 16'h0);
      chk("rst tx_data", {8'b0, bus.tx_data},  16'h0);
      chk("rst led",     {15'b0, led},         16'h0);
      chk("rst acq_en",  {15'b0, acq_en},      16'h0);
      chk("rst gain",    {8'b0, gain},         16'h0);
      chk("rst err",     {15'b0, err},         16'h0);
      reset = 1'b1;
      tick(2);

      //              n  b0     b1     b2     s0        s1        txv     t0     t1     t2     l  a  gain   e
      vecs[0]  = mk(2, 8'h81, 8'h03, 8'h00, 16'h1234, 16'h1234, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 8'h00, 0);
      vecs[1]  = mk(2, 8'h00, 8'hAA, 8'h00, 16'h1234, 16'h1234, 3'b011, 8'hEC, 8'h03, 8'h00, 1, 1, 8'h00, 0);
      vecs[2]  = mk(3, 8'h82, 8'h55, 8'h66, 16'h1234, 16'h1234, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 0);
      vecs[3]  = mk(3, 8'h04, 8'h11, 8'h22, 16'h1234, 16'hABCD, 3'b111, 8'h12, 8'h34, 8'h00, 1, 1, 8'h55, 1);
      vecs[4]  = mk(2, 8'h83, 8'h01, 8'h00, 16'h1234, 16'h1234, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 0);
      vecs[5]  = mk(3, 8'h7F, 8'h11, 8'h22, 16'h1234, 16'h1234, 3'b111, 8'h00, 8'hEC, 8'h03, 1, 1, 8'h55, 1);
      vecs[6]  = mk(2, 8'h83, 8'h01, 8'h00, 16'h1234, 16'h1234, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 0);
      vecs[7]  = mk(1, 8'h05, 8'h00, 8'h00, 16'h5678, 16'h5678, 3'b001, 8'h78, 8'h00, 8'h00, 1, 1, 8'h55, 0);
      vecs[8]  = mk(1, 8'h81, 8'h00, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 0);
      vecs[9]  = mk(2, 8'h81, 8'h00, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 8'h55, 0);
      vecs[10] = mk(2, 8'h02, 8'h11, 8'h00, 16'h5678, 16'h5678, 3'b011, 8'h55, 8'h00, 8'h00, 0, 0, 8'h55, 0);
      vecs[11] = mk(2, 8'h81, 8'h02, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 8'h55, 0);
      vecs[12] = mk(2, 8'h86, 8'h11, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 8'h55, 1);
      vecs[13] = mk(2, 8'h83, 8'h00, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 8'h55, 1);
      vecs[14] = mk(1, 8'h03, 8'h00, 8'h00, 16'h5678, 16'h5678, 3'b001, 8'h01, 8'h00, 8'h00, 0, 1, 8'h55, 1);
      vecs[15] = mk(2, 8'h83, 8'h01, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 8'h55, 0);

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Byte coinciding with cs_n rising must be dropped (CTRL currently 02).
      bus.cs_n = 1'b0;
      tick(2);
      send_byte(8'h81, sample, ld, td);
      tick(1);
      l0 = n_loads;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b1;
      bus.cs_n     = 1'b1;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      tick(2);
      chk("late_byte acq_en", {15'b0, acq_en}, 16'h1);
      chk("late_byte led",    {15'b0, led},    16'h0);
      bus.cs_n = 1'b0;
      tick(2);
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b1;
      bus.cs_n     = 1'b1;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      tick(3);
      chk("late_cmd loads", 16'(n_loads - l0), 16'h0);

      // Reset in the middle of a write frame, cs_n held low throughout.
      run_vec(mk(2, 8'h81, 8'h03, 8'h00, 16'h5678, 16'h5678, 3'b000, 8'h00, 8'h00, 8'h00,
                 1, 1, 8'h55, 0), 16);
      bus.cs_n = 1'b0;
      tick(2);
      send_byte(8'h81, sample, ld, td);
      reset = 1'b0;
      tick(1);
      chk("midrst led",    {15'b0, led},    16'h0);
      chk("midrst acq_en", {15'b0, acq_en}, 16'h0);
      chk("midrst gain",   {8'b0, gain},    16'h0);
      reset = 1'b1;
      tick(1);
      l0 = n_loads;
      send_byte(8'h03, sample, ld, td);
      tick(1);
      send_byte(8'h00, sample, ld, td);
      tick(1);
      send_byte(8'hAA, sample, ld, td);
      tick(2);
      chk("postrst led",    {15'b0, led},    16'h0);
      chk("postrst acq_en", {15'b0, acq_en}, 16'h0);
      chk("postrst loads",  16'(n_loads - l0), 16'h0);
      bus.cs_n = 1'b1;
      tick(2);

      // Write 81 03: outputs change in the cycle right after the data strobe.
      bus.cs_n = 1'b0;
      tick(2);
      send_byte(8'h81, sample, ld, td);
      bus.rx_data  = 8'h03;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      chk("wr_timing led_before", {15'b0, led}, 16'h0);
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      @(negedge clk);
      chk("wr_timing led_after", {15'b0, led},    16'h1);
      chk("wr_timing acq_after", {15'b0, acq_en}, 16'h1);
      bus.cs_n = 1'b1;
      tick(2);

      // Read ID: tx_load is a single pulse exactly one cycle after the command.
      bus.cs_n = 1'b0;
      tick(2);
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      chk("rd_timing load_same", {15'b0, bus.tx_load}, 16'h0);
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      @(negedge clk);
      chk("rd_timing load_next", {15'b0, bus.tx_load}, 16'h1);
      chk("rd_timing data_next", {8'b0, bus.tx_data},  16'h00EC);
      @(negedge clk);
      chk("rd_timing load_pulse", {15'b0, bus.tx_load}, 16'h0);
      bus.cs_n = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
